// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MAC timestep scheduler and its spike FIFO.
// Holds the scheduler state encoding and the default address/counter widths.
package mac_sched_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_TS_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_CLEAR = 3'd4
   } sched_state_e;

endpackage

// File: rtl/spike_addr_fifo.sv
// Synchronous spike-address FIFO with an extra wrap bit on each pointer
// so full and empty are told apart without a separate counter.
module spike_addr_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   // Storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mac_timestep_scheduler.sv
// Per-timestep sequencer for one MAC: init window, round-robin spike intake
// through a FIFO, one address per cycle to the MAC, and a safe end-of-step clear.
module mac_timestep_scheduler
   import mac_sched_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int FIFO_DEPTH      = 8,
   parameter int TIMESTEP_CYCLES = 16,
   parameter int INIT_CYCLES     = 2,
   parameter int TS_W            = DEF_TS_W
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic                      stop,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         mac_src_addr,
   output logic                      mac_src_valid,
   output logic                      mac_set,
   output logic                      mac_clear,
   output logic                      timestep_done,
   output logic [TS_W-1:0]           timestep_count,
   output logic                      overrun,
   output logic                      busy
);

   localparam int RR_W   = $clog2(NUM_REQ);
   localparam int SUM_W  = RR_W + 1;
   localparam int STEP_W = $clog2(TIMESTEP_CYCLES);
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);

   sched_state_e       r_state, w_state_next;
   logic [RR_W-1:0]    r_rr_ptr;
   logic [STEP_W-1:0]  r_step;
   logic [INIT_W-1:0]  r_init_cnt;
   logic [ADDR_W-1:0]  r_mac_src_addr;
   logic               r_mac_src_valid;
   logic [TS_W-1:0]    r_ts_count;
   logic               r_overrun;

   logic [ADDR_W-1:0]    w_req_addr [NUM_REQ];
   logic [2*NUM_REQ-1:0] w_valid_dbl;
   logic [NUM_REQ-1:0]   w_valid_rot;
   logic                 w_found;
   logic [RR_W-1:0]      w_off;
   logic [SUM_W-1:0]     w_sum;
   logic [RR_W-1:0]      w_gidx;
   logic [RR_W-1:0]      w_rr_next;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [ADDR_W-1:0]    w_fifo_data;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_req_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the winner.
   assign w_valid_dbl = {req_valid, req_valid} >> r_rr_ptr;
   assign w_valid_rot = w_valid_dbl[NUM_REQ-1:0];

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      if (r_state == ST_RUN && !w_fifo_full) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
               w_found = 1'b1;
               w_off   = RR_W'(k);
            end
         end
      end
   end

   assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_gidx    = (w_sum >= SUM_W'(NUM_REQ)) ? RR_W'(w_sum - SUM_W'(NUM_REQ)) : RR_W'(w_sum);
   assign w_rr_next = (w_gidx == RR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
   assign req_ready = w_found ? (NUM_REQ'(1) << w_gidx) : '0;
   assign w_push    = w_found;
   assign w_pop     = !w_fifo_empty &&
                      (r_state == ST_RUN || r_state == ST_DRAIN || r_state == ST_CLEAR);

   spike_addr_fifo #(
      .DATA_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_data  (w_req_addr[w_gidx]),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_INIT;
         ST_INIT:  if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_state_next = ST_RUN;
         ST_RUN: begin
            // A pop in the last step leaves a spike in flight, so it drains too.
            if (r_step == STEP_W'(TIMESTEP_CYCLES - 1)) begin
               w_state_next = (w_fifo_empty && !w_push) ? ST_CLEAR : ST_DRAIN;
            end
         end
         ST_DRAIN: if (w_fifo_empty && !r_mac_src_valid) w_state_next = ST_CLEAR;
         ST_CLEAR: w_state_next = stop ? ST_IDLE : ST_RUN;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state         <= ST_IDLE;
         r_rr_ptr        <= '0;
         r_step          <= '0;
         r_init_cnt      <= '0;
         r_mac_src_addr  <= '0;
         r_mac_src_valid <= 1'b0;
         r_ts_count      <= '0;
         r_overrun       <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_step          <= (r_state == ST_RUN) ? r_step + 1'b1 : '0;
         r_init_cnt      <= (r_state == ST_INIT) ? r_init_cnt + 1'b1 : '0;
         r_mac_src_valid <= w_pop;
         if (w_push) r_rr_ptr <= w_rr_next;
         if (w_pop) r_mac_src_addr <= w_fifo_data;
         if (r_state == ST_CLEAR) r_ts_count <= r_ts_count + 1'b1;
         if (r_state == ST_RUN && w_state_next == ST_DRAIN) r_overrun <= 1'b1;
      end
   end

   assign mac_src_addr   = r_mac_src_addr;
   assign mac_src_valid  = r_mac_src_valid;
   assign mac_set        = (r_state == ST_INIT);
   assign mac_clear      = (r_state == ST_CLEAR);
   assign timestep_done  = (r_state == ST_CLEAR);
   assign timestep_count = r_ts_count;
   assign overrun        = r_overrun;
   assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mac_timestep_scheduler.sv
// Bench for mac_timestep_scheduler: startup vector table, directed timestep
// sequences and random traffic, all checked against a queue-based model.
module tb_mac_timestep_scheduler;

   localparam int NR    = 4;
   localparam int AW    = 12;
   localparam int DEPTH = 8;
   localparam int T     = 16;
   localparam int IC    = 2;
   localparam int TSW   = 16;

   localparam int P_IDLE  = 0;
   localparam int P_INIT  = 1;
   localparam int P_RUN   = 2;
   localparam int P_DRAIN = 3;
   localparam int P_CLEAR = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             start;
   logic             stop;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR-1:0]    req_ready;
   logic [AW-1:0]    mac_src_addr;
   logic             mac_src_valid;
   logic             mac_set;
   logic             mac_clear;
   logic             timestep_done;
   logic [TSW-1:0]   timestep_count;
   logic             overrun;
   logic             busy;

   always #5 CLK = ~CLK;

   mac_timestep_scheduler #(
      .NUM_REQ(NR), .ADDR_W(AW), .FIFO_DEPTH(DEPTH),
      .TIMESTEP_CYCLES(T), .INIT_CYCLES(IC), .TS_W(TSW)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .mac_src_addr(mac_src_addr), .mac_src_valid(mac_src_valid),
      .mac_set(mac_set), .mac_clear(mac_clear), .timestep_done(timestep_done),
      .timestep_count(timestep_count), .overrun(overrun), .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: phase, spike queue, arbitration pointer and counters.
   int            m_phase;
   int            m_rr;
   int            m_step;
   int            m_init_left;
   logic [AW-1:0] q[$];
   logic          m_out_valid;
   logic [AW-1:0] m_out_addr;
   logic [TSW-1:0] m_tcount;
   logic          m_overrun;
   int            grants[$];

   typedef struct {
      logic          start;
      logic [NR-1:0] valid;
      logic          exp_set;
      logic          exp_busy;
      logic [NR-1:0] exp_rdy;
      logic          exp_sv;
      logic [AW-1:0] exp_addr;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_phase = P_IDLE; m_rr = 0; m_step = 0; m_init_left = 0;
      q.delete();
      m_out_valid = 1'b0; m_out_addr = '0; m_tcount = '0; m_overrun = 1'b0;
   endtask

   function automatic logic [NR-1:0] m_ready(input logic [NR-1:0] v);
      int idx;
      if (m_phase != P_RUN || q.size() >= DEPTH) return '0;
      for (int k = 0; k < NR; k++) begin
         idx = (m_rr + k) % NR;
         if (v[idx]) return NR'(1) << idx;
      end
      return '0;
   endfunction

   task automatic m_advance();
      int            sz0;
      logic          prev_v;
      logic [NR-1:0] rdy;
      bit            popped;
      sz0    = q.size();
      prev_v = m_out_valid;
      rdy    = m_ready(req_valid);
      popped = 0;
      if ((m_phase == P_RUN || m_phase == P_DRAIN || m_phase == P_CLEAR) && sz0 > 0) begin
         m_out_addr = q.pop_front();
         popped = 1;
      end
      m_out_valid = popped;
      for (int k = 0; k < NR; k++) begin
         if (rdy[k]) begin
            q.push_back(req_addr[k*AW +: AW]);
            m_rr = (k + 1) % NR;
            grants.push_back(k);
         end
      end
      case (m_phase)
         P_IDLE: if (start) begin m_phase = P_INIT; m_init_left = IC; end
         P_INIT: begin
            m_init_left--;
            if (m_init_left == 0) begin m_phase = P_RUN; m_step = 0; end
         end
         P_RUN: begin
            m_step++;
            if (m_step == T) begin
               if (q.size() == 0 && !popped) m_phase = P_CLEAR;
               else begin m_phase = P_DRAIN; m_overrun = 1'b1; end
            end
         end
         P_DRAIN: if (sz0 == 0 && !prev_v) m_phase = P_CLEAR;
         default: begin
            m_tcount = m_tcount + 1'b1;
            m_phase  = stop ? P_IDLE : P_RUN;
            m_step   = 0;
         end
      endcase
   endtask

   task automatic check_model();
      chk("req_ready",      req_ready,      m_ready(req_valid));
      chk("mac_src_valid",  mac_src_valid,  m_out_valid);
      chk("mac_src_addr",   mac_src_addr,   m_out_addr);
      chk("mac_set",        mac_set,        m_phase == P_INIT);
      chk("mac_clear",      mac_clear,      m_phase == P_CLEAR);
      chk("timestep_done",  timestep_done,  m_phase == P_CLEAR);
      chk("timestep_count", timestep_count, m_tcount);
      chk("overrun",        overrun,        m_overrun);
      chk("busy",           busy,           m_phase != P_IDLE);
   endtask

   task automatic pre(input logic s, input logic p, input logic [NR-1:0] v, input logic [NR*AW-1:0] a);
      start = s; stop = p; req_valid = v; req_addr = a;
      #3;
      check_model();
   endtask

   task automatic post();
      m_advance();
      @(posedge CLK);
      #1;
   endtask

   localparam logic [NR*AW-1:0] ADDRS = {12'd12, 12'd10, 12'd9, 12'd8};

   initial begin
      int sv_n, clr_n, last_sv, clr_at, i;
      bit sent;
      logic [NR-1:0] v;
      logic [NR*AW-1:0] a;

      //            start valid    set   busy  rdy      sv    addr
      tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 12'd0};
      tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 12'd0};
      tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 12'd0};
      tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 12'd0};
      tbl[4]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 12'd0};
      tbl[5]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b0, 12'd0};
      tbl[6]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 12'd8};
      tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 12'd9};
      tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 12'd10};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 12'd12};
      tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 12'd8};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 12'd0};

      RST = 1'b1; start = 1'b0; stop = 1'b0; req_valid = '0; req_addr = '0;
      m_reset();
      #1;
      check_model();
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Startup and round-robin table.
      for (int r = 0; r < 12; r++) begin
         pre(tbl[r].start, 1'b0, tbl[r].valid, ADDRS);
         chk($sformatf("tbl%0d_set", r),  mac_set,       tbl[r].exp_set);
         chk($sformatf("tbl%0d_busy", r), busy,          tbl[r].exp_busy);
         chk($sformatf("tbl%0d_rdy", r),  req_ready,     tbl[r].exp_rdy);
         chk($sformatf("tbl%0d_sv", r),   mac_src_valid, tbl[r].exp_sv);
         if (tbl[r].exp_sv) chk($sformatf("tbl%0d_addr", r), mac_src_addr, tbl[r].exp_addr);
         post();
      end
      chk("grant_count", grants.size(), 5);
      for (int g = 0; g < 5 && g < grants.size(); g++)
         chk($sformatf("grant%0d", g), grants[g], g % NR);

      // Finish first timestep.
      i = 0;
      while (m_phase != P_CLEAR && i < 40) begin pre(0, 0, '0, '0); post(); i++; end
      chk("ts1_reach_clear", m_phase == P_CLEAR, 1'b1);
      pre(0, 0, '0, '0);
      chk("ts1_clear_pulse", mac_clear, 1'b1);
      post();

      // Single spike at step 3.
      sv_n = 0; clr_n = 0;
      for (int c = 0; c < T + 1; c++) begin
         v = (m_phase == P_RUN && m_step == 3) ? 4'b0100 : 4'b0000;
         pre(0, 0, v, {12'd0, 12'd12, 12'd0, 12'd0});
         if (mac_src_valid) begin
            sv_n++;
            chk("single_addr", mac_src_addr, 12'd12);
         end
         if (mac_clear) clr_n++;
         if (c == T) chk("single_clear_at_end", mac_clear, 1'b1);
         post();
      end
      chk("single_sv_count", sv_n, 1);
      chk("single_clear_count", clr_n, 1);
      chk("single_tcount", timestep_count, 16'd2);
      chk("single_overrun", overrun, 1'b0);

      // Spike accepted in the last step forces DRAIN.
      sent = 0; sv_n = 0; clr_n = 0; last_sv = -1; clr_at = -1;
      for (int c = 0; c < 40; c++) begin
         v = 4'b0000;
         if (m_phase == P_RUN && m_step == T - 1 && !sent) begin v = 4'b0001; sent = 1; end
         pre(0, 0, v, {36'd0, 12'h5A5});
         if (mac_src_valid) last_sv = c;
         if (mac_clear) begin clr_n++; clr_at = c; end
         if (m_phase == P_DRAIN || m_phase == P_CLEAR) chk("drain_no_accept", req_ready, 4'b0000);
         post();
         if (clr_n > 0 && m_phase == P_RUN) break;
      end
      chk("ovr_clear_count", clr_n, 1);
      chk("ovr_clear_after_sv", clr_at > last_sv && last_sv >= 0, 1'b1);
      chk("ovr_sticky", overrun, 1'b1);

      // stop mid-timestep, with start pulses ignored while busy.
      clr_n = 0; i = 0;
      while (m_phase != P_IDLE && i < 60) begin
         pre((i % 3) == 0, m_step >= 5 || m_phase != P_RUN ? 1'b1 : 1'b0,
             4'(($urandom % 4 == 0) ? $urandom : 0), {$urandom, $urandom});
         if (mac_clear) clr_n++;
         post();
         i++;
      end
      chk("stop_one_clear", clr_n, 1);
      chk("stop_idle", busy, 1'b0);
      for (int c = 0; c < 3; c++) begin pre(0, 1, 4'b1111, ADDRS); post(); end

      // Random traffic.
      stop = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom % 40 == 0) stop = ~stop;
         v = 4'($urandom);
         if ($urandom % 3 == 0) v = '0;
         a = {$urandom, $urandom};
         pre($urandom % 12 == 0, stop, v, a);
         post();
      end

      // Asynchronous reset with traffic in flight.
      i = 0;
      while (m_phase != P_RUN && i < 60) begin pre(1, 0, '0, '0); post(); i++; end
      for (int c = 0; c < 5; c++) begin pre(0, 0, 4'b1111, ADDRS); post(); end
      pre(0, 0, 4'b1111, ADDRS);
      #1;
      RST = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_sv", mac_src_valid, 1'b0);
      chk("rst_addr", mac_src_addr, 12'd0);
      chk("rst_set", mac_set, 1'b0);
      chk("rst_clear", mac_clear, 1'b0);
      chk("rst_tcount", timestep_count, 16'd0);
      chk("rst_overrun", overrun, 1'b0);
      m_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int c = 0; c < 6; c++) begin
         pre(0, 0, 4'b1111, ADDRS);
         chk("post_rst_no_clear", mac_clear, 1'b0);
         post();
      end
      pre(1, 0, '0, '0); post();
      for (int c = 0; c < 6; c++) begin pre(0, 0, '0, '0); post(); end
      chk("post_rst_fifo_empty", mac_src_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
